// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register with stall, flush,
// invalid-slot masking of state-changing controls, and a bubble counter.
// Ports:
//   clk, reset (async, active-high)
//   StallE, FlushE    : hazard-unit hold / bubble requests
//   ValidD, *D        : decoder controls and decode-stage datapath values
//   ValidE, *E        : registered copies presented to the execute stage
//   BubbleCnt         : saturating count of flushes since reset
module id_ex_reg #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            ALUSrcD,
  input  logic            LoadD,
  input  logic            JarlD,
  input  logic            MemReadD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [2:0]      Funct3D,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ALUSrcE,
  output logic            LoadE,
  output logic            JarlE,
  output logic            MemReadE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [CNTW-1:0] BubbleCnt
);

  typedef struct packed {
    logic            valid;
    logic            regw;
    logic            memw;
    logic            br;
    logic            jmp;
    logic            alusrc;
    logic            load;
    logic            jarl;
    logic            memrd;
    logic [1:0]      rsrc;
    logic [2:0]      aluc;
    logic [2:0]      f3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pcp4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ent_t;

  ent_t            w_d;
  ent_t            r_q;
  logic [CNTW-1:0] r_cnt;

  // An invalid slot may carry x controls from a partial decode; mask
  // every bit that can change architectural state.
  always_comb begin
    w_d        = '0;
    w_d.valid  = ValidD;
    w_d.regw   = RegWriteD & ValidD;
    w_d.memw   = MemWriteD & ValidD;
    w_d.br     = BranchD & ValidD;
    w_d.jmp    = JumpD & ValidD;
    w_d.alusrc = ALUSrcD;
    w_d.load   = LoadD;
    w_d.jarl   = JarlD & ValidD;
    w_d.memrd  = MemReadD & ValidD;
    w_d.rsrc   = ResultSrcD;
    w_d.aluc   = ALUControlD;
    w_d.f3     = Funct3D;
    w_d.rd1    = RD1D;
    w_d.rd2    = RD2D;
    w_d.pc     = PCD;
    w_d.imm    = ImmExtD;
    w_d.pcp4   = PCPlus4D;
    w_d.rs1    = Rs1D;
    w_d.rs2    = Rs2D;
    w_d.rd     = RdD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (FlushE) begin
      r_q <= '0;
    end else if (!StallE) begin
      r_q <= w_d;
    end
  end

  // Counts every flush edge, stalled or not, and sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (FlushE && (r_cnt != {CNTW{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign ValidE      = r_q.valid;
  assign RegWriteE   = r_q.regw;
  assign MemWriteE   = r_q.memw;
  assign BranchE     = r_q.br;
  assign JumpE       = r_q.jmp;
  assign ALUSrcE     = r_q.alusrc;
  assign LoadE       = r_q.load;
  assign JarlE       = r_q.jarl;
  assign MemReadE    = r_q.memrd;
  assign ResultSrcE  = r_q.rsrc;
  assign ALUControlE = r_q.aluc;
  assign Funct3E     = r_q.f3;
  assign RD1E        = r_q.rd1;
  assign RD2E        = r_q.rd2;
  assign PCE         = r_q.pc;
  assign ImmExtE     = r_q.imm;
  assign PCPlus4E    = r_q.pcp4;
  assign Rs1E        = r_q.rs1;
  assign Rs2E        = r_q.rs2;
  assign RdE         = r_q.rd;
  assign BubbleCnt   = r_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: table-driven bench for id_ex_reg (CNTW=4) plus
// hand sequences for async reset and counter saturation.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  ctl;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
    logic [2:0]  f3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pcp4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } bundle_t;

  typedef struct {
    bundle_t    d;
    logic       fl;
    logic       st;
    bundle_t    e;
    logic [3:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       st = 1'b0;
  logic       fl = 1'b0;
  bundle_t    d = '0;
  bundle_t    q;
  logic [3:0] cnt;

  logic vE, rwE, mwE, brE, jE, asE, ldE, jrE, mrE;
  logic [1:0]  rsE;
  logic [2:0]  acE, f3E;
  logic [31:0] rd1E, rd2E, pcE, immE, p4E;
  logic [4:0]  rs1E, rs2E, rdE;

  int pass_n = 0;
  int total_n = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .StallE(st), .FlushE(fl),
    .ValidD(d.valid),
    .RegWriteD(d.ctl[7]), .MemWriteD(d.ctl[6]),
    .BranchD(d.ctl[5]), .JumpD(d.ctl[4]),
    .ALUSrcD(d.ctl[3]), .LoadD(d.ctl[2]),
    .JarlD(d.ctl[1]), .MemReadD(d.ctl[0]),
    .ResultSrcD(d.rsrc), .ALUControlD(d.aluc),
    .Funct3D(d.f3), .RD1D(d.rd1), .RD2D(d.rd2),
    .PCD(d.pc), .ImmExtD(d.imm), .PCPlus4D(d.pcp4),
    .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
    .ValidE(vE), .RegWriteE(rwE), .MemWriteE(mwE),
    .BranchE(brE), .JumpE(jE), .ALUSrcE(asE),
    .LoadE(ldE), .JarlE(jrE), .MemReadE(mrE),
    .ResultSrcE(rsE), .ALUControlE(acE), .Funct3E(f3E),
    .RD1E(rd1E), .RD2E(rd2E), .PCE(pcE), .ImmExtE(immE),
    .PCPlus4E(p4E), .Rs1E(rs1E), .Rs2E(rs2E), .RdE(rdE),
    .BubbleCnt(cnt)
  );

  assign q = {vE, rwE, mwE, brE, jE, asE, ldE, jrE, mrE,
              rsE, acE, f3E, rd1E, rd2E, pcE, immE, p4E,
              rs1E, rs2E, rdE};

  function automatic bundle_t mkb(
    input logic v, input logic [7:0] c, input logic [1:0] rs,
    input logic [2:0] ac, input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] p, input logic [31:0] im,
    input logic [4:0] s1, input logic [4:0] s2,
    input logic [4:0] r);
    bundle_t t;
    t = '{valid: v, ctl: c, rsrc: rs, aluc: ac, f3: f,
          rd1: a, rd2: b, pc: p, imm: im, pcp4: p + 32'd4,
          rs1: s1, rs2: s2, rd: r};
    return t;
  endfunction

  task automatic chk_b(input string nm, input bundle_t exp);
    total_n++;
    if (q === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, q, exp);
  endtask

  task automatic chk_c(input string nm, input logic [3:0] exp);
    total_n++;
    if (cnt === exp) pass_n++;
    else $display("FAIL %s: BubbleCnt got %0d want %0d", nm, cnt, exp);
  endtask

  vec_t    tv[11];
  bundle_t lw, a0, sw, inv, invx;

  initial begin
    lw = mkb(1, 8'b1000_1101, 2'b01, 3'b000, 3'b010,
             32'h1000, 32'h0, 32'h38, 32'h8, 5'd2, 5'd0, 5'd5);
    a0 = mkb(1, 8'b1000_1000, 2'b00, 3'b000, 3'b000,
             32'h7, 32'h0, 32'h40, 32'h5, 5'd1, 5'd0, 5'd3);
    sw = mkb(1, 8'b0100_1000, 2'b00, 3'b000, 3'b010,
             32'h2000, 32'hdead, 32'h54, 32'hc, 5'd4, 5'd6, 5'd0);
    inv = mkb(0, 8'b1111_1111, 2'b10, 3'b001, 3'b000,
              32'h11, 32'h22, 32'h60, 32'h4, 5'd8, 5'd9, 5'd7);
    invx = mkb(0, 8'b0000_1100, 2'b10, 3'b001, 3'b000,
               32'h11, 32'h22, 32'h60, 32'h4, 5'd8, 5'd9, 5'd7);

    tv[0] = '{lw, 0, 0, lw, 4'd0};
    tv[1] = '{a0, 0, 0, a0, 4'd0};
    for (int k = 0; k < 3; k++) begin
      tv[2+k] = '{a0, 0, 1, a0, 4'd0};
      tv[2+k].d.pc = 32'h44 + 32'(4 * k);
      tv[2+k].d.pcp4 = 32'h48 + 32'(4 * k);
    end
    tv[5] = '{a0, 0, 0, a0, 4'd0};
    tv[5].d.pc = 32'h50;
    tv[5].d.pcp4 = 32'h54;
    tv[5].e = tv[5].d;
    tv[6] = '{sw, 1, 1, '0, 4'd1};
    tv[7] = '{inv, 0, 0, invx, 4'd1};
    tv[8] = '{lw, 1, 0, '0, 4'd2};
    tv[9] = '{lw, 1, 0, '0, 4'd3};
    tv[10] = '{lw, 0, 0, lw, 4'd3};

    // Load all-ones, then reset asynchronously between edges.
    d = '1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_b("rst_async_ent", '0);
    chk_c("rst_async_cnt", 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_b("rst_hold_ent", '0);
    chk_c("rst_hold_cnt", 4'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      d = tv[i].d;
      fl = tv[i].fl;
      st = tv[i].st;
      @(posedge clk);
      #1;
      chk_b($sformatf("vec%0d_ent", i), tv[i].e);
      chk_c($sformatf("vec%0d_cnt", i), tv[i].cnt);
    end

    // Mid-cycle reset clears entry and counter without an edge.
    #2;
    reset = 1'b1;
    #1;
    chk_b("rst_mid_ent", '0);
    chk_c("rst_mid_cnt", 4'd0);
    @(negedge clk);
    reset = 1'b0;
    fl = 1'b0;
    st = 1'b0;

    // 20 consecutive flushes: 1..15 then held at 15.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      d = lw;
      fl = 1'b1;
      @(posedge clk);
      #1;
      chk_c($sformatf("sat%0d", i), (i + 1 > 15) ? 4'd15 : 4'(i + 1));
      if (i == 19) chk_b("sat_ent", '0);
    end
    @(negedge clk);
    fl = 1'b0;

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
